// File: rtl/uart_transmitter.sv
// uart_transmitter: frames parallel words as start bit, LSB-first data bits
// and stop bits on a serial line. sample_clk runs at twice the baud rate, so
// every bit is held for two clock cycles. A one-word holding register lets
// the next word be queued so that frames can follow each other with no gap.
module uart_transmitter #(
  parameter int DATA_WIDTH_NUMBER = 8,
  parameter int STOP_BITS_NUMBER  = 2
) (
  input  logic                         sample_clk,
  input  logic                         rst_n,
  input  logic [DATA_WIDTH_NUMBER-1:0] data_in,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic                         data_out,
  output logic                         tx_busy,
  output logic                         tx_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [4:0] LAST_IDX  = 5'(DATA_WIDTH_NUMBER - 1);
  localparam logic [3:0] STOP_LAST = 4'(2 * STOP_BITS_NUMBER - 1);

  logic [1:0]                   state;
  logic [DATA_WIDTH_NUMBER-1:0] hold_reg;
  logic                         hold_full;
  logic [DATA_WIDTH_NUMBER-1:0] shift_reg;
  logic [DATA_WIDTH_NUMBER-1:0] next_shift;
  logic [4:0]                   bit_idx;
  logic [3:0]                   cnt;
  logic                         stop_end;
  logic                         load;

  // Frame-boundary decode: last stop cycle, and when the held word moves on
  always_comb begin
    stop_end   = (state == S_STOP) && (cnt == STOP_LAST);
    load       = hold_full && ((state == S_IDLE) || stop_end);
    next_shift = shift_reg >> 1;
  end

  // Status outputs come straight from registers; tx_ready never sees tx_valid
  always_comb begin
    tx_ready = !hold_full;
    tx_busy  = (state != S_IDLE);
  end

  // Holding register: filled on handshake, emptied when the FSM takes the word
  always_ff @(posedge sample_clk) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_reg  <= '0;
    end else if (load) begin
      hold_full <= 1'b0;
    end else if (tx_valid && !hold_full) begin
      hold_reg  <= data_in;
      hold_full <= 1'b1;
    end
  end

  // Frame sequencer: start, data bits and stop bits, two cycles per bit
  always_ff @(posedge sample_clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      bit_idx   <= '0;
      cnt       <= '0;
      data_out  <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        S_IDLE: begin
          data_out <= 1'b1;
          if (load) begin
            shift_reg <= hold_reg;
            data_out  <= 1'b0;
            cnt       <= '0;
            state     <= S_START;
          end
        end
        S_START: begin
          if (cnt[0]) begin
            data_out <= shift_reg[0];
            bit_idx  <= '0;
            cnt      <= '0;
            state    <= S_DATA;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_DATA: begin
          if (cnt[0]) begin
            cnt <= '0;
            if (bit_idx == LAST_IDX) begin
              data_out <= 1'b1;
              state    <= S_STOP;
            end else begin
              // shift rather than index so a 1-bit word needs no special case
              bit_idx   <= bit_idx + 5'd1;
              shift_reg <= next_shift;
              data_out  <= next_shift[0];
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_STOP: begin
          if (stop_end) begin
            tx_done <= 1'b1;
            cnt     <= '0;
            if (hold_full) begin
              shift_reg <= hold_reg;
              data_out  <= 1'b0;
              state     <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: a default instance and a 5-bit/1-stop instance
// are compared every cycle with a frame-position reference model; a serial
// decoder on the default instance recovers words against a scoreboard.
module tb_uart_transmitter;

  localparam int W0 = 8;
  localparam int S0 = 2;
  localparam int W1 = 5;
  localparam int S1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [W0-1:0] din0;
  logic [W1-1:0] din1;
  logic          v0, v1;
  logic          rdy0, rdy1, line0, line1, busy0, busy1, done0, done1;

  uart_transmitter dut0 (
    .sample_clk(clk), .rst_n(rst_n), .data_in(din0), .tx_valid(v0),
    .tx_ready(rdy0), .data_out(line0), .tx_busy(busy0), .tx_done(done0)
  );

  uart_transmitter #(.DATA_WIDTH_NUMBER(W1), .STOP_BITS_NUMBER(S1)) dut1 (
    .sample_clk(clk), .rst_n(rst_n), .data_in(din1), .tx_valid(v1),
    .tx_ready(rdy1), .data_out(line1), .tx_busy(busy1), .tx_done(done1)
  );

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // m_pos: cycle index inside the current frame, -1 when the line is idle
  int          m_pos  [2] = '{-1, -1};
  logic        m_hold [2] = '{1'b0, 1'b0};
  logic        m_done [2] = '{1'b0, 1'b0};
  logic [15:0] m_word [2];
  logic [15:0] m_hword[2];
  int          m_acc  [2] = '{0, 0};
  int          m_w    [2] = '{W0, W1};
  int          m_s    [2] = '{S0, S1};

  logic [7:0] sb[$];
  int         dpos = -1;

  function automatic logic exp_line(input int i);
    if (m_pos[i] < 0) return 1'b1;
    if (m_pos[i] < 2) return 1'b0;
    if (m_pos[i] < 2 + 2 * m_w[i]) return m_word[i][(m_pos[i] - 2) / 2];
    return 1'b1;
  endfunction

  always @(posedge clk) begin : model_b
    logic        vi;
    logic [15:0] di;
    logic        hb;
    int          flen;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      vi = (i == 0) ? v0 : v1;
      di = (i == 0) ? 16'(din0) : 16'(din1);
      if (!rst_n) begin
        m_pos[i]  = -1;
        m_hold[i] = 1'b0;
        m_done[i] = 1'b0;
        if (i == 0) begin
          sb.delete();
          dpos = -1;
        end
      end else begin
        flen      = 2 * (1 + m_w[i] + m_s[i]);
        hb        = m_hold[i];
        m_done[i] = 1'b0;
        if (m_pos[i] >= 0) begin
          m_pos[i]++;
          if (m_pos[i] == flen) begin
            m_done[i] = 1'b1;
            m_pos[i]  = -1;
          end
        end
        if (m_pos[i] < 0 && hb) begin
          m_pos[i]  = 0;
          m_word[i] = m_hword[i];
          m_hold[i] = 1'b0;
        end
        if (vi && !hb) begin
          m_hold[i]  = 1'b1;
          m_hword[i] = di;
          m_acc[i]++;
          if (i == 0) sb.push_back(di[7:0]);
        end
      end
    end
  end

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("line0",  32'(line0), 32'(exp_line(0)));
    check("ready0", 32'(rdy0),  32'(!m_hold[0]));
    check("busy0",  32'(busy0), 32'(m_pos[0] >= 0));
    check("done0",  32'(done0), 32'(m_done[0]));
    check("line1",  32'(line1), 32'(exp_line(1)));
    check("ready1", 32'(rdy1),  32'(!m_hold[1]));
    check("busy1",  32'(busy1), 32'(m_pos[1] >= 0));
    check("done1",  32'(done1), 32'(m_done[1]));
  end

  // ---------------- serial decoder on the default instance ----------------
  int         starts[$];
  int         done_cnt  = 0;
  int         done1_cnt = 0;
  logic [7:0] dword;
  logic       stop_bad = 1'b0;

  always @(negedge clk) begin
    if (dpos < 0) begin
      if (line0 === 1'b0) begin
        dpos = 0;
        starts.push_back(cyc);
      end
    end else begin
      dpos++;
    end
    if (dpos >= 0) begin
      if (dpos >= 2 && dpos < 2 + 2 * W0 && (dpos % 2) == 1) dword[(dpos - 2) / 2] = line0;
      if (dpos >= 2 + 2 * W0 && line0 !== 1'b1) stop_bad = 1'b1;
      if (dpos == 2 * (1 + W0 + S0) - 1) begin
        check("stop_bits", 32'(stop_bad), 32'd0);
        if (sb.size() == 0) check("frame_extra", 32'd1, 32'd0);
        else check("frame_word", 32'(dword), 32'(sb.pop_front()));
        dpos     = -1;
        stop_bad = 1'b0;
      end
    end
    if (done0 === 1'b1) done_cnt++;
    if (done1 === 1'b1) done1_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int i, input logic [15:0] d, output int acc_cyc);
    int a;
    a = m_acc[i];
    if (i == 0) begin din0 = d[W0-1:0]; v0 = 1'b1; end
    else        begin din1 = d[W1-1:0]; v1 = 1'b1; end
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (m_acc[i] != a) break;
    end
    acc_cyc = cyc;
    check("accept_timeout", 32'(m_acc[i] != a), 32'd1);
    if (i == 0) v0 = 1'b0;
    else        v1 = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    logic ok;
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (m_pos[i] < 0 && !m_hold[i]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("idle_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    int   k, d0, n, acc3, pa0, pa1;
    logic hit;
    rst_n = 1'b0;
    v0 = 1'b1; v1 = 1'b1;
    din0 = 8'h5A; din1 = 5'h1F;

    // reset with valid held high: nothing may be captured
    repeat (3) @(negedge clk);
    check("rst_line",  32'(line0), 32'd1);
    check("rst_ready", 32'(rdy0),  32'd1);
    check("rst_busy",  32'(busy0), 32'd0);
    check("rst_done",  32'(done0), 32'd0);
    v0 = 1'b0; v1 = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_no_capture", 32'(busy0 | busy1 | !rdy0 | !rdy1), 32'd0);

    // single frame 0xA5
    d0 = done_cnt;
    n  = starts.size();
    send(0, 16'h00A5, k);
    wait_idle(0);
    repeat (2) @(negedge clk);
    check("a5_start_delay", 32'(starts[n] - k), 32'd1);
    check("a5_done_count",  32'(done_cnt - d0), 32'd1);

    // back-to-back 0x00, 0xFF, then 0x3C offered while the holder is full
    d0 = done_cnt;
    n  = starts.size();
    send(0, 16'h0000, k);
    send(0, 16'h00FF, k);
    send(0, 16'h003C, acc3);
    wait_idle(0);
    repeat (2) @(negedge clk);
    check("b2b_gap1",  32'(starts[n + 1] - starts[n]), 32'd22);
    check("b2b_gap2",  32'(starts[n + 2] - starts[n + 1]), 32'd22);
    check("b2b_done",  32'(done_cnt - d0), 32'd3);
    check("bp_accept", 32'(acc3), 32'(starts[n + 1] + 1));

    // reset during data bit 3
    d0 = done_cnt;
    send(0, 16'h0096, k);
    hit = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (m_pos[0] == 2 + 2 * 3) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("mid_rst_reach", 32'(hit), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_line", 32'(line0), 32'd1);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("mid_rst_done",  32'(done_cnt - d0), 32'd0);
    check("mid_rst_ready", 32'(rdy0), 32'd1);
    check("mid_rst_busy",  32'(busy0), 32'd0);

    // 5 data bits, 1 stop bit
    d0 = done1_cnt;
    send(1, 16'h0013, k);
    wait_idle(1);
    repeat (2) @(negedge clk);
    check("p_done_count", 32'(done1_cnt - d0), 32'd1);

    // randomized traffic on both instances
    pa0 = m_acc[0];
    pa1 = m_acc[1];
    for (int t = 0; t < 1500; t++) begin
      @(negedge clk);
      if (v0 && m_acc[0] != pa0) v0 = 1'b0;
      if (!v0 && $urandom_range(3) == 0) begin v0 = 1'b1; din0 = W0'($urandom); end
      if (v1 && m_acc[1] != pa1) v1 = 1'b0;
      if (!v1 && $urandom_range(3) == 0) begin v1 = 1'b1; din1 = W1'($urandom); end
      pa0 = m_acc[0];
      pa1 = m_acc[1];
    end
    v0 = 1'b0; v1 = 1'b0;
    @(negedge clk);
    wait_idle(0);
    wait_idle(1);
    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
